// File: rtl/random_pulse_gen_multi_pkg.sv
// Shared constants and helpers for the multi-channel random pulse generator:
// maximal-length Galois tap masks and per-channel seed derivation.
package rpg_pkg;

    localparam logic [31:0] TAP_MASK_8  = 32'h0000_00B8;
    localparam logic [31:0] TAP_MASK_16 = 32'h0000_B400;
    localparam logic [31:0] TAP_MASK_32 = 32'h8020_0003;
    localparam logic [31:0] SEED_SALT   = 32'h9E37_79B9;

    function automatic logic [31:0] tap_mask(input int unsigned width);
        case (width)
            8:       return TAP_MASK_8;
            32:      return TAP_MASK_32;
            default: return TAP_MASK_16;
        endcase
    endfunction

    function automatic logic [31:0] width_mask(input int unsigned width);
        if (width >= 32)
            return 32'hFFFF_FFFF;
        return (32'h1 << width) - 32'h1;
    endfunction

    // Channel seeds are decorrelated by a golden-ratio salt; an all-zero
    // result would lock the LFSR, so it is forced to 1.
    function automatic logic [31:0] derive_seed(input logic [31:0] base,
                                                input int unsigned idx,
                                                input int unsigned width);
        logic [31:0] s;
        s = (base ^ (SEED_SALT * idx)) & width_mask(width);
        if (s == 32'h0)
            s = 32'h1;
        return s;
    endfunction

endpackage

// File: rtl/random_pulse_gen_multi_lfsr_galois.sv
// Right-shifting Galois LFSR with clock enable and synchronous parallel load.
module lfsr_galois
    import rpg_pkg::*;
#(
    parameter int unsigned      WIDTH   = 16,
    parameter logic [WIDTH-1:0] TAPS    = WIDTH'(tap_mask(WIDTH)),
    parameter logic [WIDTH-1:0] RST_VAL = WIDTH'(1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ce,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] state
);

    logic [WIDTH-1:0] r_state;
    logic [WIDTH-1:0] w_next;

    assign w_next = r_state[0] ? ((r_state >> 1) ^ TAPS) : (r_state >> 1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_state <= RST_VAL;
        else if (load)
            r_state <= load_val;
        else if (ce)
            r_state <= w_next;
    end

    assign state = r_state;

endmodule

// File: rtl/random_pulse_gen_multi.sv
// Multi-channel random pulse generator: one Galois LFSR per channel, pulse when
// the state is below a live threshold, with a per-channel minimum idle gap.
module random_pulse_gen_multi
    import rpg_pkg::*;
#(
    parameter int unsigned WIDTH        = 16,
    parameter int unsigned CHANNELS     = 4,
    parameter int unsigned GAP_W        = 8,
    parameter logic [31:0] DEFAULT_SEED = 32'h0000_ACE1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ce,
    input  logic                seed_load,
    input  logic [WIDTH-1:0]    seed,
    input  logic [WIDTH-1:0]    threshold,
    input  logic [GAP_W-1:0]    min_gap,
    input  logic [CHANNELS-1:0] chan_en,
    output logic [CHANNELS-1:0] q
);

    localparam logic [WIDTH-1:0] TAPS = WIDTH'(tap_mask(WIDTH));

    // Saturating gap update: reload on a pulse, otherwise count down to zero.
    function automatic logic [GAP_W-1:0] gap_next(input logic             fire,
                                                  input logic [GAP_W-1:0] cur,
                                                  input logic [GAP_W-1:0] reload);
        if (fire)
            return reload;
        if (cur != '0)
            return cur - GAP_W'(1);
        return '0;
    endfunction

    logic [WIDTH-1:0] w_state [CHANNELS];

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        localparam logic [WIDTH-1:0] RST_SEED = WIDTH'(derive_seed(DEFAULT_SEED, i, WIDTH));

        logic [WIDTH-1:0] w_load_val;
        logic             w_fire;
        logic [GAP_W-1:0] r_gap;
        logic             r_q;

        assign w_load_val = WIDTH'(derive_seed(32'(seed), i, WIDTH));

        lfsr_galois #(
            .WIDTH  (WIDTH),
            .TAPS   (TAPS),
            .RST_VAL(RST_SEED)
        ) u_lfsr (
            .clk     (clk),
            .rst     (rst),
            .ce      (ce),
            .load    (seed_load),
            .load_val(w_load_val),
            .state   (w_state[i])
        );

        // Decision uses the pre-advance LFSR value; the register makes q lag by one edge.
        assign w_fire = chan_en[i] && (w_state[i] < threshold) && (r_gap == '0);

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_gap <= '0;
                r_q   <= 1'b0;
            end else if (seed_load) begin
                r_gap <= '0;
                r_q   <= 1'b0;
            end else if (ce) begin
                r_gap <= gap_next(w_fire, r_gap, min_gap);
                r_q   <= w_fire;
            end else begin
                r_q   <= 1'b0;
            end
        end

        assign q[i] = r_q;
    end

endmodule

// File: tb/tb_random_pulse_gen_multi.sv
// Directed bench for random_pulse_gen_multi: hand-computed vector table plus
// multi-cycle sequences checked against a cycle-level reference model.
module tb_random_pulse_gen_multi;

    localparam int CH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        ce;
    logic        seed_load;
    logic [15:0] seed;
    logic [15:0] threshold;
    logic [7:0]  min_gap;
    logic [3:0]  chan_en;
    logic [3:0]  q;

    int n_checks = 0;
    int n_pass   = 0;

    logic [15:0] m_lfsr [CH];
    logic [7:0]  m_gap  [CH];

    typedef struct {
        logic        c;
        logic        ld;
        logic [15:0] sd;
        logic [15:0] th;
        logic [7:0]  mg;
        logic [3:0]  en;
        logic [3:0]  eq;
        logic [15:0] es;
    } vec_t;

    vec_t tbl [15];

    random_pulse_gen_multi #(
        .WIDTH       (16),
        .CHANNELS    (4),
        .GAP_W       (8),
        .DEFAULT_SEED(32'h0000_ACE1)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .ce       (ce),
        .seed_load(seed_load),
        .seed     (seed),
        .threshold(threshold),
        .min_gap  (min_gap),
        .chan_en  (chan_en),
        .q        (q)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] gstep(input logic [15:0] s);
        return s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
    endfunction

    function automatic logic [15:0] mseed(input logic [15:0] base, input int i);
        logic [31:0] p;
        logic [15:0] s;
        p = 32'h9E37_79B9 * 32'(i);
        s = base ^ p[15:0];
        if (s == 16'h0)
            s = 16'h1;
        return s;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp)
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        else
            n_pass++;
    endtask

    function automatic logic [63:0] dut_states();
        logic [63:0] v;
        for (int i = 0; i < CH; i++)
            v[16*i +: 16] = dut.w_state[i];
        return v;
    endfunction

    function automatic logic [63:0] model_states();
        logic [63:0] v;
        for (int i = 0; i < CH; i++)
            v[16*i +: 16] = m_lfsr[i];
        return v;
    endfunction

    task automatic model_reset(input logic [15:0] base);
        for (int i = 0; i < CH; i++) begin
            m_lfsr[i] = mseed(base, i);
            m_gap[i]  = 8'h0;
        end
    endtask

    // One clock: drive inputs, advance the model, sample 1ns after the edge.
    task automatic cyc(input logic c, input logic ld, input logic [15:0] sd,
                       input logic [15:0] th, input logic [7:0] mg,
                       input logic [3:0] en, input string tag);
        logic [3:0] e_q;
        logic       f;
        ce = c; seed_load = ld; seed = sd; threshold = th; min_gap = mg; chan_en = en;
        e_q = 4'h0;
        if (ld) begin
            model_reset(sd);
        end else if (c) begin
            for (int i = 0; i < CH; i++) begin
                f = en[i] && (m_lfsr[i] < th) && (m_gap[i] == 8'h0);
                e_q[i] = f;
                m_gap[i] = f ? mg : ((m_gap[i] != 8'h0) ? m_gap[i] - 8'h1 : 8'h0);
                m_lfsr[i] = gstep(m_lfsr[i]);
            end
        end
        @(posedge clk);
        #1;
        check({tag, "_q"}, 64'(q), 64'(e_q));
        check({tag, "_state"}, dut_states(), model_states());
    endtask

    initial begin
        int          last [CH];
        int          min_sp [CH];
        logic [3:0]  seen;

        rst = 1'b1; ce = 1'b0; seed_load = 1'b0; seed = 16'h0;
        threshold = 16'h0; min_gap = 8'h0; chan_en = 4'h0;

        // ce, ld, seed, thr, gap, en, exp q, exp ch0 state
        tbl[0]  = '{1'b0, 1'b1, 16'h0001, 16'h0000, 8'd0, 4'h1, 4'h0, 16'h0001};
        tbl[1]  = '{1'b1, 1'b0, 16'h0000, 16'h8000, 8'd0, 4'h1, 4'h1, 16'hB400};
        tbl[2]  = '{1'b1, 1'b0, 16'h0000, 16'h8000, 8'd0, 4'h1, 4'h0, 16'h5A00};
        tbl[3]  = '{1'b1, 1'b0, 16'h0000, 16'h8000, 8'd0, 4'h1, 4'h1, 16'h2D00};
        tbl[4]  = '{1'b0, 1'b0, 16'h0000, 16'h8000, 8'd0, 4'h1, 4'h0, 16'h2D00};
        tbl[5]  = '{1'b1, 1'b0, 16'h0000, 16'h8000, 8'd2, 4'h1, 4'h1, 16'h1680};
        tbl[6]  = '{1'b1, 1'b0, 16'h0000, 16'h8000, 8'd2, 4'h1, 4'h0, 16'h0B40};
        tbl[7]  = '{1'b1, 1'b0, 16'h0000, 16'h8000, 8'd2, 4'h1, 4'h0, 16'h05A0};
        tbl[8]  = '{1'b1, 1'b0, 16'h0000, 16'h8000, 8'd0, 4'h1, 4'h1, 16'h02D0};
        tbl[9]  = '{1'b1, 1'b0, 16'h0000, 16'h8000, 8'd0, 4'h0, 4'h0, 16'h0168};
        tbl[10] = '{1'b1, 1'b0, 16'h0000, 16'h0100, 8'd0, 4'h1, 4'h0, 16'h00B4};
        tbl[11] = '{1'b1, 1'b0, 16'h0000, 16'h00B4, 8'd0, 4'h1, 4'h0, 16'h005A};
        tbl[12] = '{1'b1, 1'b0, 16'h0000, 16'h005B, 8'd0, 4'h1, 4'h1, 16'h002D};
        tbl[13] = '{1'b1, 1'b1, 16'h0000, 16'h005B, 8'd0, 4'h1, 4'h0, 16'h0001};
        tbl[14] = '{1'b1, 1'b0, 16'h0000, 16'h0002, 8'd0, 4'h1, 4'h1, 16'hB400};

        // Reset state
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        model_reset(16'hACE1);
        check("rst_q", 64'(q), 64'h0);
        check("rst_s0", 64'(dut.w_state[0]), 64'hACE1);
        check("rst_s1", 64'(dut.w_state[1]), 64'hD558);
        check("rst_all", dut_states(), model_states());

        // Hand-computed vector table
        for (int k = 0; k < 15; k++) begin
            ce = tbl[k].c; seed_load = tbl[k].ld; seed = tbl[k].sd;
            threshold = tbl[k].th; min_gap = tbl[k].mg; chan_en = tbl[k].en;
            @(posedge clk); #1;
            check($sformatf("tbl%0d_q", k), 64'(q), 64'(tbl[k].eq));
            check($sformatf("tbl%0d_s0", k), 64'(dut.w_state[0]), 64'(tbl[k].es));
        end

        // Mid-run async reset
        cyc(1'b1, 1'b1, 16'h1234, 16'hFFFF, 8'd0, 4'hF, "resync");
        for (int k = 0; k < 6; k++)
            cyc(1'b1, 1'b0, 16'h0, 16'hFFFF, 8'd0, 4'hF, "pre_rst");
        rst = 1'b1;
        #2;
        check("async_rst_q", 64'(q), 64'h0);
        check("async_rst_s0", 64'(dut.w_state[0]), 64'hACE1);
        check("async_rst_s1", 64'(dut.w_state[1]), 64'hD558);
        @(posedge clk); #3;
        rst = 1'b0;
        model_reset(16'hACE1);
        check("post_rst_all", dut_states(), model_states());
        check("post_rst_q", 64'(q), 64'h0);

        // threshold = 0 never fires
        seen = 4'h0;
        for (int k = 0; k < 1000; k++) begin
            cyc(1'b1, 1'b0, 16'h0, 16'h0000, 8'd0, 4'hF, "thr0");
            seen |= q;
        end
        check("thr0_never", 64'(seen), 64'h0);

        // Full threshold: back-to-back, then min_gap=3
        for (int k = 0; k < 20; k++)
            cyc(1'b1, 1'b0, 16'h0, 16'hFFFF, 8'd0, 4'hF, "full_g0");
        for (int i = 0; i < CH; i++) begin
            last[i] = -100;
            min_sp[i] = 1000;
        end
        for (int k = 0; k < 40; k++) begin
            cyc(1'b1, 1'b0, 16'h0, 16'hFFFF, 8'd3, 4'hF, "full_g3");
            for (int i = 0; i < CH; i++) begin
                if (q[i]) begin
                    if (last[i] >= 0 && (k - last[i]) < min_sp[i])
                        min_sp[i] = k - last[i];
                    last[i] = k;
                end
            end
        end
        for (int i = 0; i < CH; i++)
            check($sformatf("gap3_spacing_ch%0d", i), 64'(min_sp[i]), 64'd4);

        // Golden sequence from seed 1 for 256 steps, then zero-seed guard
        cyc(1'b0, 1'b1, 16'h0001, 16'h0000, 8'd0, 4'hF, "load1");
        for (int k = 0; k < 256; k++)
            cyc(1'b1, 1'b0, 16'h0, 16'h0000, 8'd0, 4'hF, "seq256");
        cyc(1'b0, 1'b1, 16'h0000, 16'h0000, 8'd0, 4'hF, "load0");
        check("load0_s0", 64'(dut.w_state[0]), 64'h0001);

        // ce pattern 1,0,0,1
        for (int k = 0; k < 12; k++)
            cyc((k % 4 == 0) || (k % 4 == 3), 1'b0, 16'h0, 16'h8000, 8'd0, 4'hF, "ce_pat");

        // Channel 2 disabled for 50 cycles, then re-enabled
        seen = 4'h0;
        for (int k = 0; k < 50; k++) begin
            cyc(1'b1, 1'b0, 16'h0, 16'h8000, 8'd1, 4'hB, "ch2_off");
            seen |= q;
        end
        check("ch2_off_q", 64'(seen[2]), 64'h0);
        for (int k = 0; k < 50; k++)
            cyc(1'b1, 1'b0, 16'h0, 16'h8000, 8'd1, 4'hF, "ch2_on");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
